// File: rtl/fetch_unit.sv
// Instruction fetch stage: launches req/ack reads at the current PC and buffers
// returned words with their addresses in a 2-entry FIFO toward decode.
module fetch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             flush,
  output logic             pc_advance,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [WIDTH-1:0] fifo_addr [2];
  logic [WIDTH-1:0] fifo_word [2];

  logic             pop;
  logic             push;
  logic             launch;
  logic [1:0]       count_after_pop;

  assign instr_valid     = (count != 2'd0);
  assign instr           = fifo_word[rd_ptr];
  assign instr_pc        = fifo_addr[rd_ptr];
  assign pop             = instr_valid && instr_ready;
  assign push            = (state == BUSY) && imem_ack && !flush;
  assign pc_advance      = push;
  assign count_after_pop = count - {1'b0, pop};
  // A pop in the launch cycle frees the slot early enough to launch on the same edge.
  assign launch          = (state == IDLE) && !flush && (count_after_pop < 2'd2);

  // Request FSM: a launched read is always carried to its ack, even across a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Instruction buffer: flush clears occupancy and pointers, overriding push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_word[i] <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= imem_addr;
        fifo_word[wr_ptr] <= imem_rdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_after_pop + {1'b0, push};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model (request flag, doomed flag, and a queue of fetched words).
module tb_fetch_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc;
  logic         flush;
  logic         pc_advance;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         instr_ready;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [63:0] q[$];
  bit          m_req;
  bit          m_dead;
  logic [31:0] m_addr;

  // Memory responder and PC register control
  int wcnt;
  int wait_cfg;
  bit prev_req;
  bit branch_en;

  logic        exp_req, exp_adv, exp_valid;
  logic [31:0] exp_addr, exp_instr, exp_ipc;
  logic        act_req, act_adv, act_valid;
  logic [31:0] act_addr, act_instr, act_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h00A0_0093;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // advance the model, then move to the next falling edge.
  task automatic cycle(input bit rdy, input bit fl, input bit r, input logic [31:0] redirect);
    int sz;
    bit m_pop, m_launch;
    if (act_adv === 1'b1)
      pc = (branch_en && $urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0FFC) : pc + 32'd4;
    if (fl) pc = redirect;
    rst = r;
    flush = fl;
    instr_ready = rdy;
    if (imem_req === 1'b1) begin
      if (!prev_req) wcnt = (wait_cfg < 0) ? $urandom_range(0, 3) : wait_cfg;
      if (wcnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        wcnt--;
      end
    end else begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    #1;
    act_req = imem_req; act_addr = imem_addr; act_adv = pc_advance;
    act_valid = instr_valid; act_instr = instr; act_ipc = instr_pc;
    prev_req = (imem_req === 1'b1);
    exp_req = m_req; exp_addr = m_addr;
    exp_valid = (q.size() != 0);
    exp_instr = exp_valid ? q[0][31:0] : 32'h0;
    exp_ipc = exp_valid ? q[0][63:32] : 32'h0;
    exp_adv = m_req && imem_ack && !m_dead && !fl;
    if (r) begin
      q.delete(); m_req = 0; m_dead = 0; m_addr = 0;
    end else begin
      sz = q.size();
      m_pop = exp_valid && rdy;
      m_launch = !m_req && !fl && (sz - int'(m_pop)) < 2;
      if (fl) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (exp_adv) q.push_back({m_addr, imem_rdata});
      end
      if (m_req) begin
        if (imem_ack) begin m_req = 0; m_dead = 0; end
        else if (fl) m_dead = 1;
      end else if (m_launch) begin
        m_req = 1; m_addr = pc;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    cycle(0, 0, 1, 0);
    pc = start_pc;
    act_adv = 1'b0;
    wait_cfg = 0;
  endtask

  task automatic test_reset();
    do_reset(0);
    cycle(0, 1, 1, 0);
    nvec++; if (act_req !== 1'b0) begin nerr++; $display("FAIL rst_req: got %b want 0", act_req); end
    nvec++; if (act_addr !== 32'h0) begin nerr++; $display("FAIL rst_addr: got %h want 0", act_addr); end
    nvec++; if (act_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", act_valid); end
    nvec++; if (act_instr !== 32'h0) begin nerr++; $display("FAIL rst_instr: got %h want 0", act_instr); end
    nvec++; if (act_ipc !== 32'h0) begin nerr++; $display("FAIL rst_instr_pc: got %h want 0", act_ipc); end
    nvec++; if (act_adv !== 1'b0) begin nerr++; $display("FAIL rst_adv: got %b want 0", act_adv); end
    act_adv = 1'b0;
  endtask

  task automatic test_zero_wait();
    int advs = 0;
    do_reset(32'h0);
    for (int c = 0; c < 9; c++) begin
      cycle(1, 0, 0, 0);
      if (act_adv === 1'b1) advs++;
      if (c == 1) begin
        nvec++;
        if (act_req !== 1'b1 || act_addr !== 32'h0 || act_adv !== 1'b1) begin
          nerr++; $display("FAIL zw_fetch0: req=%b addr=%h adv=%b want 1/00000000/1", act_req, act_addr, act_adv);
        end
      end
      if (c == 2) begin
        nvec++;
        if (act_valid !== 1'b1 || act_instr !== 32'h00A00093 || act_ipc !== 32'h0 || act_adv !== 1'b0) begin
          nerr++; $display("FAIL zw_instr0: valid=%b instr=%h pc=%h adv=%b want 1/00a00093/00000000/0", act_valid, act_instr, act_ipc, act_adv);
        end
      end
      if (c == 3) begin
        nvec++;
        if (act_req !== 1'b1 || act_addr !== 32'h4 || act_adv !== 1'b1) begin
          nerr++; $display("FAIL zw_fetch4: req=%b addr=%h adv=%b want 1/00000004/1", act_req, act_addr, act_adv);
        end
      end
      if (c == 4) begin
        nvec++;
        if (act_valid !== 1'b1 || act_instr !== mem_word(32'h4) || act_ipc !== 32'h4) begin
          nerr++; $display("FAIL zw_instr4: valid=%b instr=%h pc=%h want 1/%h/00000004", act_valid, act_instr, act_ipc, mem_word(32'h4));
        end
      end
    end
    nvec++; if (advs != 4) begin nerr++; $display("FAIL zw_adv_pulses: got %0d want 4", advs); end
  endtask

  task automatic test_wait_states();
    int advs = 0;
    int held = 0;
    do_reset(32'h100);
    wait_cfg = 3;
    for (int c = 0; c < 6; c++) begin
      cycle(1, 0, 0, 0);
      if (act_adv === 1'b1) advs++;
      if (c >= 1 && c <= 4 && act_req === 1'b1 && act_addr === 32'h100) held++;
      if (c == 4) begin
        nvec++; if (act_valid !== 1'b0 || act_adv !== 1'b1) begin
          nerr++; $display("FAIL ws_ack_cycle: valid=%b adv=%b want 0/1", act_valid, act_adv);
        end
      end
      if (c == 5) begin
        nvec++; if (act_valid !== 1'b1 || act_ipc !== 32'h100) begin
          nerr++; $display("FAIL ws_valid: valid=%b pc=%h want 1/00000100", act_valid, act_ipc);
        end
      end
    end
    nvec++; if (held != 4) begin nerr++; $display("FAIL ws_req_held: got %0d cycles want 4", held); end
    nvec++; if (advs != 1) begin nerr++; $display("FAIL ws_adv_pulses: got %0d want 1", advs); end
  endtask

  task automatic test_backpressure();
    int advs = 0;
    do_reset(32'h0);
    for (int c = 0; c < 6; c++) begin
      cycle(0, 0, 0, 0);
      if (act_adv === 1'b1) advs++;
    end
    nvec++; if (advs != 2) begin nerr++; $display("FAIL bp_adv_pulses: got %0d want 2", advs); end
    nvec++; if (act_req !== 1'b0 || pc !== 32'h8) begin
      nerr++; $display("FAIL bp_stalled: req=%b pc=%h want 0/00000008", act_req, pc);
    end
    nvec++; if (act_valid !== 1'b1 || act_ipc !== 32'h0) begin
      nerr++; $display("FAIL bp_head: valid=%b pc=%h want 1/00000000", act_valid, act_ipc);
    end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    nvec++; if (act_valid !== 1'b1 || act_ipc !== 32'h4 || act_instr !== mem_word(32'h4)) begin
      nerr++; $display("FAIL bp_second: valid=%b pc=%h instr=%h want 1/00000004/%h", act_valid, act_ipc, act_instr, mem_word(32'h4));
    end
    nvec++; if (act_req !== 1'b1 || act_addr !== 32'h8) begin
      nerr++; $display("FAIL bp_relaunch: req=%b addr=%h want 1/00000008", act_req, act_addr);
    end
  endtask

  task automatic test_flush_busy();
    do_reset(32'h20);
    wait_cfg = 2;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 32'h40);
    for (int c = 2; c < 4; c++) begin
      cycle(1, 0, 0, 0);
      nvec++; if (act_req !== 1'b1 || act_addr !== 32'h20 || act_adv !== 1'b0) begin
        nerr++; $display("FAIL fb_drain%0d: req=%b addr=%h adv=%b want 1/00000020/0", c, act_req, act_addr, act_adv);
      end
    end
    cycle(1, 0, 0, 0);
    nvec++; if (act_valid !== 1'b0 || act_req !== 1'b0) begin
      nerr++; $display("FAIL fb_dropped: valid=%b req=%b want 0/0", act_valid, act_req);
    end
    cycle(1, 0, 0, 0);
    nvec++; if (act_req !== 1'b1 || act_addr !== 32'h40) begin
      nerr++; $display("FAIL fb_redirect: req=%b addr=%h want 1/00000040", act_req, act_addr);
    end
  endtask

  task automatic test_flush_ack();
    do_reset(32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 32'h80);
    nvec++; if (act_valid !== 1'b1 || act_req !== 1'b1 || act_adv !== 1'b0) begin
      nerr++; $display("FAIL fa_ack_cycle: valid=%b req=%b adv=%b want 1/1/0", act_valid, act_req, act_adv);
    end
    cycle(0, 0, 0, 0);
    nvec++; if (act_valid !== 1'b0 || act_req !== 1'b0) begin
      nerr++; $display("FAIL fa_cleared: valid=%b req=%b want 0/0", act_valid, act_req);
    end
    cycle(0, 0, 0, 0);
    nvec++; if (act_req !== 1'b1 || act_addr !== 32'h80) begin
      nerr++; $display("FAIL fa_redirect: req=%b addr=%h want 1/00000080", act_req, act_addr);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset(32'h10);
    wait_cfg = 5;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    nvec++; if (act_req !== 1'b1 || act_addr !== 32'h10) begin
      nerr++; $display("FAIL rb_busy: req=%b addr=%h want 1/00000010", act_req, act_addr);
    end
    cycle(0, 0, 0, 0);
    nvec++; if (act_req !== 1'b0 || act_addr !== 32'h0 || act_valid !== 1'b0) begin
      nerr++; $display("FAIL rb_after: req=%b addr=%h valid=%b want 0/00000000/0", act_req, act_addr, act_valid);
    end
  endtask

  task automatic test_random();
    bit rdy, fl, r;
    do_reset(32'h0);
    wait_cfg = -1;
    branch_en = 1;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 499) == 0);
      cycle(rdy, fl, r, $urandom & 32'h0000_0FFC);
      nvec++; if (act_req !== exp_req) begin nerr++; $display("FAIL rnd_req @%0d: got %b want %b", i, act_req, exp_req); end
      nvec++; if (act_addr !== exp_addr) begin nerr++; $display("FAIL rnd_addr @%0d: got %h want %h", i, act_addr, exp_addr); end
      nvec++; if (act_adv !== exp_adv) begin nerr++; $display("FAIL rnd_adv @%0d: got %b want %b", i, act_adv, exp_adv); end
      nvec++; if (act_valid !== exp_valid) begin nerr++; $display("FAIL rnd_valid @%0d: got %b want %b", i, act_valid, exp_valid); end
      if (exp_valid) begin
        nvec++; if (act_instr !== exp_instr || act_ipc !== exp_ipc) begin
          nerr++; $display("FAIL rnd_head @%0d: got %h@%h want %h@%h", i, act_instr, act_ipc, exp_instr, exp_ipc);
        end
      end
    end
    branch_en = 0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; pc = '0; wait_cfg = 0; wcnt = 0; branch_en = 0;
    prev_req = 0; act_adv = 1'b0; m_req = 0; m_dead = 0; m_addr = 0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_flush_busy();
    test_flush_ack();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the program-counter unit. It captures the current `pc`, runs a req/ack read transaction against instruction memory, and stores each returned word with its address in a 2-entry buffer. The buffer feeds decode over a valid/ready handshake. The block drives `pc_advance` back to the PC register as its load enable, so the PC (sequential or branch target selected by `pcsrc`) moves only after a fetch has completed.

## Interface
- `WIDTH`, 32, data and address width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  WIDTH  current PC from the PC register.
- `flush`  in  1  redirect: discard buffered and in-flight instructions.
- `pc_advance`  out  1  load enable for the PC register (combinational).
- `imem_req`  out  1  read request (registered).
- `imem_addr`  out  WIDTH  read address (registered; stable while `imem_req`=1).
- `imem_ack`  in  1  read done; `imem_rdata` valid this cycle. Sampled only while `imem_req`=1.
- `imem_rdata`  in  WIDTH  instruction word.
- `instr_valid`  out  1  buffer non-empty.
- `instr`  out  WIDTH  head-entry instruction.
- `instr_pc`  out  WIDTH  head-entry address.
- `instr_ready`  in  1  decode accepts the head entry.

## Operation
- Storage: 2-entry FIFO of {addr, word}, with read pointer, write pointer and count (0..2).
- `instr_valid` = (count != 0).
- `instr` and `instr_pc` always show the head entry.
- Pop = `instr_valid` && `instr_ready`.
- FSM states: IDLE, BUSY, DRAIN.
  - **IDLE:** `imem_req`=0. If !`flush` and (count − pop) < 2: `imem_addr`<=`pc`, `imem_req`<=1, go to BUSY. Otherwise stay in IDLE.
  - **BUSY:** `imem_req`=1 and `imem_addr` held.
    - `imem_ack` && !`flush`: push {`imem_addr`, `imem_rdata`}, `pc_advance`=1, `imem_req`<=0, go to IDLE.
    - `imem_ack` && `flush`: drop the word, `pc_advance`=0, go to IDLE.
    - !`imem_ack` && `flush`: go to DRAIN.
    - Otherwise stay in BUSY.
  - **DRAIN:** `imem_req`=1 with the old address. On `imem_ack`: drop the word, `imem_req`<=0, go to IDLE. `flush` while in DRAIN has no extra effect.
- `pc_advance` = (state==BUSY) && `imem_ack` && !`flush`, with no other source.
- Flush:
  - count<=0 and both pointers<=0 on the same edge.
  - Any pop or push in that cycle is overridden.
  - A transaction that is in flight is never abandoned. The memory always sees req held until ack.
- Overflow cannot occur: a launch requires room, and count cannot rise while BUSY until that launch's own push.
- Simultaneous push and pop: count unchanged, and both pointers advance (mod 2).
- Pop while empty is ignored.
- `imem_rdata` is not checked; any value is stored verbatim.

## Timing
- Reset values: state IDLE, count 0, pointers 0, `imem_req` 0, `imem_addr` 0, all FIFO entries 0. Consequently `instr_valid` 0, `instr` 0, `instr_pc` 0, `pc_advance` 0.
- Reset has priority over `flush` and all handshakes.
- Reset during BUSY or DRAIN drops the transaction immediately. The memory must tolerate req falling without ack after reset.
- Launch: `pc` sampled at edge E; `imem_req`=1 and `imem_addr`=`pc` from cycle E+1.
- Zero-wait memory: ack in the first req cycle is allowed. Earliest push is at the end of cycle E+1, giving `instr_valid`=1 in cycle E+2.
- Ack after N wait cycles: `instr_valid` rises N cycles later than the zero-wait case.
- `pc_advance` is high in the ack cycle. The PC register loads `next_pc` at that edge, and the following IDLE cycle launches with the new `pc`.
- Peak throughput is 1 instruction per 2 cycles (IDLE, BUSY alternate).
- Decode stall: with count=2, no launch occurs. A pop in an IDLE cycle allows a launch at that same edge.
- After `flush` at edge F, `instr_valid`=0 from cycle F+1.
  - Flush in IDLE or BUSY+ack: first new launch samples `pc` at edge F+1 at the earliest.
  - Flush in BUSY without ack: the new launch comes after DRAIN completes.

## Test plan
- **Reset, zero-wait stream:** `pc`=0x00, ack same cycle as req, `instr_ready`=1. Expect `imem_addr`=0x00 then 0x04, `pc_advance` pulses every 2 cycles, and `instr`/`instr_pc` pairs match memory (e.g. 0x00A00093 @0x00).
- **Wait states:** ack held off 3 cycles. Expect `imem_req` and `imem_addr` stable for 4 cycles, exactly one `pc_advance` pulse, and `instr_valid` 1 cycle after ack.
- **Backpressure:** `instr_ready`=0. Expect count reaches 2 with entries @0x00 and @0x04, `imem_req` stays 0, `pc` frozen. Raise ready for 1 cycle: @0x00 popped and a new launch at 0x08.
- **Flush in BUSY before ack:** ack arrives 2 cycles later. Expect DRAIN, data dropped, `pc_advance`=0, `instr_valid`=0. Next launch uses the redirected `pc` (e.g. 0x40).
- **Flush with ack in the same cycle, FIFO holding 1 entry:** expect no push, no `pc_advance`, count=0 next cycle.
- **Reset asserted mid-BUSY:** expect `imem_req`=0, `instr_valid`=0 and `imem_addr`=0 on the next cycle.
